// File: rtl/hazard_pkg.sv
// ---------------------------------------------------------------------------
// hazard_pkg
// Shared types and constants for the pipeline hazard controller.
//   state_t     : controller states (RUN, BR_WAIT)
//   ST_RUN/ST_BR_WAIT : state encodings as plain logic constants
//   NOP_INSTR   : all-zero instruction word loaded on a flush
//   SB_MAX      : largest pending-write count per register (EX, MEM, WB)
//   sb_next()   : saturating next value of one scoreboard counter
// ---------------------------------------------------------------------------
package hazard_pkg;

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        BR_WAIT = 1'b1
    } state_t;

    localparam logic [0:0]  ST_RUN     = RUN;
    localparam logic [0:0]  ST_BR_WAIT = BR_WAIT;

    localparam logic [21:0] NOP_INSTR  = 22'b0;
    localparam logic [1:0]  SB_MAX     = 2'd3;

    // Issue and retire on the same register cancel; otherwise step once,
    // holding at the ends of the range instead of wrapping.
    function automatic logic [1:0] sb_next(input logic [1:0] cnt,
                                           input logic       inc,
                                           input logic       dec);
        logic [1:0] res;
        case ({inc, dec})
            2'b10:   res = (cnt == SB_MAX) ? cnt : cnt + 2'd1;
            2'b01:   res = (cnt == 2'd0)   ? cnt : cnt - 2'd1;
            default: res = cnt;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard
// Per-register pending-write counters and the RAW hazard compare.
//   clk, rst           : clock, asynchronous active-high reset
//   inc_en, inc_addr   : an instruction writing inc_addr issues to execute
//   dec_en, dec_addr   : writeback commits a write to dec_addr
//   src, src_used      : three decode source addresses (src1 in LSBs) + mask
//   hz                 : some used source still has a write in flight
//   busy               : per-register "write in flight" flags
// ---------------------------------------------------------------------------
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NREG      = 16,
    parameter int AW        = 4,
    parameter int WB_BYPASS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc_en,
    input  logic [AW-1:0]     inc_addr,
    input  logic              dec_en,
    input  logic [AW-1:0]     dec_addr,
    input  logic [3*AW-1:0]   src,
    input  logic [2:0]        src_used,
    output logic              hz,
    output logic [NREG-1:0]   busy
);

    logic [1:0] cnt_r [NREG];

    // Pending-write counters, one per architectural register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                cnt_r[r] <= 2'd0;
            end
        end else begin
            for (int r = 0; r < NREG; r++) begin
                cnt_r[r] <= sb_next(cnt_r[r],
                                    inc_en && (inc_addr == AW'(r)),
                                    dec_en && (dec_addr == AW'(r)));
            end
        end
    end

    // Busy flags straight from the counters.
    always_comb begin
        busy = {NREG{1'b0}};
        for (int r = 0; r < NREG; r++) begin
            busy[r] = (cnt_r[r] != 2'd0);
        end
    end

    // Hazard compare. With write-before-read in the register file, the last
    // outstanding write landing this cycle is already visible to decode.
    always_comb begin
        hz = 1'b0;
        for (int k = 0; k < 3; k++) begin
            for (int r = 0; r < NREG; r++) begin
                hz = hz || (src_used[k] &&
                            (src[k*AW +: AW] == AW'(r)) &&
                            (cnt_r[r] != 2'd0) &&
                            !((WB_BYPASS != 0) && (cnt_r[r] == 2'd1) &&
                              dec_en && (dec_addr == AW'(r))));
            end
        end
    end

endmodule

// File: rtl/hazard_controller.sv
// ---------------------------------------------------------------------------
// hazard_controller
// Pipeline sequencing: RAW stalls from a write scoreboard and a branch-wait
// sequence that holds fetch until writeback redirects the PC.
//   clk, rst        : pipeline clock, asynchronous active-high reset
//   dec_*           : decode-stage instruction usage (sources, dest, branch)
//   wb_*            : writeback feedback (register write, PC update)
//   fd_enable       : fetch->decode register / PC advance (0 = hold)
//   fd_flush        : load a NOP into fetch->decode
//   de_bubble       : load zero controls into decode->execute
//   busy            : per-register pending-write flags
//   br_error        : sticky, a branch never resolved within BR_TIMEOUT
//   stall_cycles    : saturating count of bubble cycles
// ---------------------------------------------------------------------------
module hazard_controller
    import hazard_pkg::*;
#(
    parameter int NREG       = 16,
    parameter int AW         = 4,
    parameter int WB_BYPASS  = 1,
    parameter int BR_TIMEOUT = 8,
    parameter int PERF_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dec_valid,
    input  logic [3*AW-1:0]   dec_src,
    input  logic [2:0]        dec_src_used,
    input  logic              dec_writes_reg,
    input  logic [AW-1:0]     dec_dest,
    input  logic              dec_pc_src,
    input  logic              wb_reg_write,
    input  logic [AW-1:0]     wb_dest,
    input  logic              wb_pc_src,
    output logic              fd_enable,
    output logic              fd_flush,
    output logic              de_bubble,
    output logic [NREG-1:0]   busy,
    output logic              br_error,
    output logic [PERF_W-1:0] stall_cycles
);

    localparam int            TW       = $clog2(BR_TIMEOUT + 1);
    localparam logic [TW-1:0] TMR_LAST = TW'(BR_TIMEOUT - 1);

    logic              hz_s;
    logic              issue_s;
    logic              err_set_s;
    logic [0:0]        state_r;
    logic [0:0]        state_nxt_s;
    logic [TW-1:0]     timer_r;
    logic [TW-1:0]     timer_nxt_s;
    logic              br_error_r;
    logic [PERF_W-1:0] stall_r;

    // A register-writing instruction enters execute only when not bubbled.
    assign issue_s = dec_valid && !de_bubble && dec_writes_reg;

    hazard_scoreboard #(
        .NREG      (NREG),
        .AW        (AW),
        .WB_BYPASS (WB_BYPASS)
    ) u_sb (
        .clk      (clk),
        .rst      (rst),
        .inc_en   (issue_s),
        .inc_addr (dec_dest),
        .dec_en   (wb_reg_write),
        .dec_addr (wb_dest),
        .src      (dec_src),
        .src_used (dec_src_used),
        .hz       (hz_s),
        .busy     (busy)
    );

    // Pipeline controls and next-state; everything is idle while in reset.
    always_comb begin
        fd_enable   = 1'b1;
        fd_flush    = 1'b0;
        de_bubble   = 1'b0;
        state_nxt_s = state_r;
        timer_nxt_s = timer_r;
        err_set_s   = 1'b0;
        if (rst) begin
            state_nxt_s = ST_RUN;
        end else begin
            case (state_r)
                ST_RUN: begin
                    // A hazard wins over a branch: the branch waits in decode.
                    if (hz_s && dec_valid) begin
                        fd_enable = 1'b0;
                        de_bubble = 1'b1;
                    end else if (dec_valid && dec_pc_src) begin
                        fd_flush    = 1'b1;
                        state_nxt_s = ST_BR_WAIT;
                        timer_nxt_s = {TW{1'b0}};
                    end else begin
                        fd_enable = 1'b1;
                    end
                end
                ST_BR_WAIT: begin
                    fd_enable = 1'b0;
                    fd_flush  = 1'b1;
                    de_bubble = 1'b1;
                    if (wb_pc_src) begin
                        state_nxt_s = ST_RUN;
                    end else if (timer_r == TMR_LAST) begin
                        err_set_s   = 1'b1;
                        state_nxt_s = ST_RUN;
                    end else begin
                        timer_nxt_s = timer_r + TW'(1);
                    end
                end
                default: begin
                    state_nxt_s = ST_RUN;
                end
            endcase
        end
    end

    // FSM state and branch-wait timer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_RUN;
            timer_r <= {TW{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            timer_r <= timer_nxt_s;
        end
    end

    // Sticky branch-timeout flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            br_error_r <= 1'b0;
        end else if (err_set_s) begin
            br_error_r <= 1'b1;
        end else begin
            br_error_r <= br_error_r;
        end
    end

    // Saturating bubble-cycle counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_r <= {PERF_W{1'b0}};
        end else if (de_bubble && (stall_r != {PERF_W{1'b1}})) begin
            stall_r <= stall_r + PERF_W'(1);
        end else begin
            stall_r <= stall_r;
        end
    end

    assign br_error     = br_error_r;
    assign stall_cycles = stall_r;

endmodule

// File: tb/tb_hazard_controller.sv
// ---------------------------------------------------------------------------
// tb_hazard_controller
// Directed stimulus against hazard_controller with a behavioural model that
// tracks pending writes as plain integers and the branch wait as a flag.
// ---------------------------------------------------------------------------
module tb_hazard_controller;
    import hazard_pkg::*;

    localparam int WB_BYPASS  = 1;
    localparam int BR_TIMEOUT = 8;

    logic        clk;
    logic        rst;
    logic        dec_valid;
    logic [11:0] dec_src;
    logic [2:0]  dec_src_used;
    logic        dec_writes_reg;
    logic [3:0]  dec_dest;
    logic        dec_pc_src;
    logic        wb_reg_write;
    logic [3:0]  wb_dest;
    logic        wb_pc_src;
    logic        fd_enable;
    logic        fd_flush;
    logic        de_bubble;
    logic [15:0] busy;
    logic        br_error;
    logic [15:0] stall_cycles;

    hazard_controller #(
        .NREG(16), .AW(4), .WB_BYPASS(WB_BYPASS), .BR_TIMEOUT(BR_TIMEOUT), .PERF_W(16)
    ) dut (
        .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_src(dec_src),
        .dec_src_used(dec_src_used), .dec_writes_reg(dec_writes_reg),
        .dec_dest(dec_dest), .dec_pc_src(dec_pc_src), .wb_reg_write(wb_reg_write),
        .wb_dest(wb_dest), .wb_pc_src(wb_pc_src), .fd_enable(fd_enable),
        .fd_flush(fd_flush), .de_bubble(de_bubble), .busy(busy),
        .br_error(br_error), .stall_cycles(stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end else begin
            passes++;
        end
    endtask

    // ---------------- behavioural model ----------------
    int mcnt [16];
    int ncnt [16];
    bit mbr, nbr;
    int mtimer, ntimer;
    bit merr, nerr;
    int mstall, nstall;

    // Predict outputs from model state and current inputs, then the next state.
    always @(negedge clk) begin : model_cmp
        int  s;
        int  n;
        bit  mhz;
        bit  een, efl, ebub;
        bit  inc, dec;
        logic [15:0] ebusy;
        if (!rst) begin
            mhz = 1'b0;
            for (int k = 0; k < 3; k++) begin
                if (dec_src_used[k]) begin
                    s = int'(dec_src[k*4 +: 4]);
                    if (mcnt[s] > 0 &&
                        !(WB_BYPASS == 1 && mcnt[s] == 1 && wb_reg_write && int'(wb_dest) == s))
                        mhz = 1'b1;
                end
            end
            if (mbr) begin
                een = 1'b0; efl = 1'b1; ebub = 1'b1;
            end else if (mhz && dec_valid) begin
                een = 1'b0; efl = 1'b0; ebub = 1'b1;
            end else if (dec_valid && dec_pc_src) begin
                een = 1'b1; efl = 1'b1; ebub = 1'b0;
            end else begin
                een = 1'b1; efl = 1'b0; ebub = 1'b0;
            end
            for (int r = 0; r < 16; r++) ebusy[r] = (mcnt[r] != 0);
            chk("fd_enable", {31'b0, fd_enable}, {31'b0, een});
            chk("fd_flush", {31'b0, fd_flush}, {31'b0, efl});
            chk("de_bubble", {31'b0, de_bubble}, {31'b0, ebub});
            chk("busy", {16'b0, busy}, {16'b0, ebusy});
            chk("br_error", {31'b0, br_error}, {31'b0, merr});
            chk("stall_cycles", {16'b0, stall_cycles}, mstall);

            for (int r = 0; r < 16; r++) begin
                inc = dec_valid && !ebub && dec_writes_reg && int'(dec_dest) == r;
                dec = wb_reg_write && int'(wb_dest) == r;
                n = mcnt[r] + int'(inc) - int'(dec);
                if (n < 0 || n > int'(SB_MAX)) begin
                    checks++;
                    $display("FAIL sb_saturate: reg %0d count %0d out of range", r, n);
                    n = (n < 0) ? 0 : int'(SB_MAX);
                end
                ncnt[r] <= n;
            end
            if (mbr) begin
                if (wb_pc_src) begin
                    nbr <= 1'b0; ntimer <= mtimer; nerr <= merr;
                end else if (mtimer + 1 == BR_TIMEOUT) begin
                    nbr <= 1'b0; ntimer <= mtimer + 1; nerr <= 1'b1;
                end else begin
                    nbr <= 1'b1; ntimer <= mtimer + 1; nerr <= merr;
                end
            end else if (dec_valid && dec_pc_src && !mhz) begin
                nbr <= 1'b1; ntimer <= 0; nerr <= merr;
            end else begin
                nbr <= 1'b0; ntimer <= mtimer; nerr <= merr;
            end
            nstall <= (ebub && mstall < 65535) ? mstall + 1 : mstall;
        end
    end

    // Commit the predicted state on the clock; reset clears everything.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < 16; r++) begin
                mcnt[r] <= 0;
                ncnt[r] <= 0;
            end
            mbr <= 1'b0; nbr <= 1'b0; mtimer <= 0; ntimer <= 0;
            merr <= 1'b0; nerr <= 1'b0; mstall <= 0; nstall <= 0;
        end else begin
            for (int r = 0; r < 16; r++) mcnt[r] <= ncnt[r];
            mbr <= nbr; mtimer <= ntimer; merr <= nerr; mstall <= nstall;
        end
    end

    // ---------------- stimulus helpers ----------------
    int          bub_n, fde0_n, fl_n;
    logic        last_en, last_fl, last_err;
    logic [15:0] last_busy, last_stall;

    task automatic step(input logic v, input logic [3:0] s1, input logic [3:0] s2,
                        input logic [3:0] s3, input logic [2:0] used, input logic wr,
                        input logic [3:0] dst, input logic br, input logic wbw,
                        input logic [3:0] wbd, input logic wbpc);
        dec_valid = v; dec_src = {s3, s2, s1}; dec_src_used = used;
        dec_writes_reg = wr; dec_dest = dst; dec_pc_src = br;
        wb_reg_write = wbw; wb_dest = wbd; wb_pc_src = wbpc;
        @(negedge clk);
        last_en = fd_enable; last_fl = fd_flush; last_err = br_error;
        last_busy = busy; last_stall = stall_cycles;
        if (de_bubble) bub_n++;
        if (!fd_enable) fde0_n++;
        if (fd_flush) fl_n++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 4'd0, 4'd0, 4'd0, 3'b000, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0);
    endtask

    task automatic wb(input logic [3:0] d);
        step(1'b0, 4'd0, 4'd0, 4'd0, 3'b000, 1'b0, 4'd0, 1'b0, 1'b1, d, 1'b0);
    endtask

    task automatic wr(input logic [3:0] d);
        step(1'b1, 4'd0, 4'd0, 4'd0, 3'b000, 1'b1, d, 1'b0, 1'b0, 4'd0, 1'b0);
    endtask

    // Younger instruction sitting in decode behind a branch.
    task automatic junk(input logic wbpc);
        step(1'b1, 4'd4, 4'd0, 4'd0, 3'b001, 1'b1, 4'd9, 1'b0, 1'b0, 4'd0, wbpc);
    endtask

    task automatic clear_inputs();
        dec_valid = 1'b0; dec_src = 12'd0; dec_src_used = 3'b000;
        dec_writes_reg = 1'b0; dec_dest = 4'd0; dec_pc_src = 1'b0;
        wb_reg_write = 1'b0; wb_dest = 4'd0; wb_pc_src = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bub_n = 0; fde0_n = 0; fl_n = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        clear_inputs();
        dec_valid = 1'b1; dec_pc_src = 1'b1;
        @(negedge clk);
        chk("rst_fd_enable", {31'b0, fd_enable}, 32'd1);
        chk("rst_fd_flush", {31'b0, fd_flush}, 32'd0);
        chk("rst_de_bubble", {31'b0, de_bubble}, 32'd0);
        chk("rst_busy", {16'b0, busy}, 32'd0);
        chk("rst_br_error", {31'b0, br_error}, 32'd0);
        chk("rst_stall", {16'b0, stall_cycles}, 32'd0);
        do_reset();

        // A: independent stream, writes R1-R3, reads R4-R6.
        step(1'b1, 4'd4, 4'd5, 4'd0, 3'b011, 1'b1, 4'd1, 1'b0, 1'b0, 4'd0, 1'b0);
        step(1'b1, 4'd6, 4'd0, 4'd0, 3'b001, 1'b1, 4'd2, 1'b0, 1'b0, 4'd0, 1'b0);
        step(1'b1, 4'd4, 4'd5, 4'd6, 3'b111, 1'b1, 4'd3, 1'b0, 1'b0, 4'd0, 1'b0);
        wb(4'd1); wb(4'd2); wb(4'd3); idle();
        chk("A_bubbles", bub_n, 32'd0);
        chk("A_stall", {16'b0, last_stall}, 32'd0);
        chk("A_busy_end", {16'b0, last_busy}, 32'd0);

        // B: write R1 then read R1; bypass leaves two bubbles.
        do_reset();
        wr(4'd1);
        step(1'b1, 4'd1, 4'd0, 4'd0, 3'b001, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0);
        chk("B_busy1_set", {31'b0, last_busy[1]}, 32'd1);
        step(1'b1, 4'd1, 4'd0, 4'd0, 3'b001, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0);
        step(1'b1, 4'd1, 4'd0, 4'd0, 3'b001, 1'b0, 4'd0, 1'b0, 1'b1, 4'd1, 1'b0);
        idle();
        chk("B_bubbles", bub_n, 32'd2);
        chk("B_fd_hold", fde0_n, 32'd2);
        chk("B_busy1_clr", {31'b0, last_busy[1]}, 32'd0);
        chk("B_stall", {16'b0, last_stall}, 32'd2);

        // C: three writes in flight to R5.
        do_reset();
        wr(4'd5); wr(4'd5); wr(4'd5);
        chk("C_model_cnt5", mcnt[5], 32'd3);
        wb(4'd5); wb(4'd5); wb(4'd5);
        chk("C_busy5_after2", {31'b0, last_busy[5]}, 32'd1);
        idle();
        chk("C_busy5_after3", {31'b0, last_busy[5]}, 32'd0);
        chk("C_bubbles", bub_n, 32'd0);

        // D: issue and writeback on R7 in the same cycle.
        do_reset();
        wr(4'd7); idle(); idle();
        step(1'b1, 4'd0, 4'd0, 4'd0, 3'b000, 1'b1, 4'd7, 1'b0, 1'b1, 4'd7, 1'b0);
        chk("D_model_cnt7", mcnt[7], 32'd1);
        idle();
        chk("D_busy7_held", {31'b0, last_busy[7]}, 32'd1);
        idle(); wb(4'd7); idle();
        chk("D_busy7_clr", {31'b0, last_busy[7]}, 32'd0);

        // E: branch resolved three cycles after issue.
        do_reset();
        step(1'b1, 4'd0, 4'd0, 4'd0, 3'b000, 1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0);
        junk(1'b0); junk(1'b0); junk(1'b1);
        idle();
        chk("E_flush_cycles", fl_n, 32'd4);
        chk("E_bubbles", bub_n, 32'd3);
        chk("E_no_issue", {16'b0, last_busy}, 32'd0);
        chk("E_run_enable", {31'b0, last_en}, 32'd1);
        chk("E_run_flush", {31'b0, last_fl}, 32'd0);

        // F: branch never resolved, then reset in the middle of a wait.
        do_reset();
        step(1'b1, 4'd0, 4'd0, 4'd0, 3'b000, 1'b1, 4'd3, 1'b1, 1'b0, 4'd0, 1'b0);
        for (int i = 0; i < 8; i++) junk(1'b0);
        chk("F_err_not_yet", {31'b0, last_err}, 32'd0);
        idle();
        chk("F_err_set", {31'b0, last_err}, 32'd1);
        chk("F_back_to_run", {31'b0, last_fl}, 32'd0);
        step(1'b1, 4'd0, 4'd0, 4'd0, 3'b000, 1'b1, 4'd3, 1'b1, 1'b0, 4'd0, 1'b0);
        junk(1'b0);
        chk("F_in_wait", {31'b0, last_fl}, 32'd1);
        chk("F_busy3_pre", {31'b0, last_busy[3]}, 32'd1);
        chk("F_stall_pre", {16'b0, last_stall}, 32'd8);
        dec_valid = 1'b1; dec_pc_src = 1'b1; dec_writes_reg = 1'b1; dec_dest = 4'd6;
        #2;
        rst = 1'b1;
        #1;
        chk("F_rst_fd_enable", {31'b0, fd_enable}, 32'd1);
        chk("F_rst_fd_flush", {31'b0, fd_flush}, 32'd0);
        chk("F_rst_de_bubble", {31'b0, de_bubble}, 32'd0);
        chk("F_rst_busy", {16'b0, busy}, 32'd0);
        chk("F_rst_br_error", {31'b0, br_error}, 32'd0);
        chk("F_rst_stall", {16'b0, stall_cycles}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_inputs();
        idle();
        chk("F_after_rst_busy", {16'b0, last_busy}, 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/hazard_controller.md
# hazard_controller

Sequencing controller for the five-stage 22-bit pipelined processor. Its inputs are decode-stage register usage and writeback-stage feedback. It drives the enable on the fetch→decode register, the bubble insert into the decode→execute register, and the flush of the fetch→decode register. It replaces the constant-enable pipeline registers with a scoreboard-based RAW stall and a branch-wait sequence, so the pipeline runs correct code without compiler-inserted NOPs.

## Interface
- NREG, 16, number of architectural registers
- AW, 4, register address width
- WB_BYPASS, 1, 1 = register file writes before read in the same cycle, so a WB write clears a hazard in that cycle
- BR_TIMEOUT, 8, max cycles in BR_WAIT before `br_error`
- PERF_W, 16, stall counter width

Ports:
- clk  in  1  pipeline clock
- rst  in  1  reset, asynchronous, active-high
- dec_valid  in  1  decode register holds a real instruction
- dec_src  in  3×AW  source registers rd1/rd2/rd3 of the decode instruction
- dec_src_used  in  3  per-source use mask
- dec_writes_reg  in  1  decode instruction's reg_write
- dec_dest  in  AW  decode write register
- dec_pc_src  in  1  decode instruction writes PC (branch)
- wb_reg_write  in  1  writeback register write
- wb_dest  in  AW  writeback register
- wb_pc_src  in  1  writeback PC update
- fd_enable  out  1  enable of the fetch→decode register and PC hold (0 = hold)
- fd_flush  out  1  load NOP into the fetch→decode register
- de_bubble  out  1  load all-zero controls into the decode→execute register
- busy  out  NREG  per-register pending-write flag
- br_error  out  1  sticky: branch never resolved within BR_TIMEOUT
- stall_cycles  out  PERF_W  saturating count of cycles with de_bubble=1

## Operation
- Scoreboard: one 2-bit pending counter per register (max 3 writes in flight: EX, MEM, WB).
  - Increment on issue: `dec_valid & ~de_bubble & dec_writes_reg`, at `dec_dest`.
  - Decrement on `wb_reg_write`, at `wb_dest`.
  - Increment and decrement on the same register in the same cycle: counter unchanged.
  - Decrement at zero, or increment at 3: counter saturates and the sticky `br_error` is **not** set. A bench assertion flags these cases.
  - `busy[r] = (cnt[r] != 0)`.
- RAW hazard: `hz` = any used source `s` with `busy[s]`. When `WB_BYPASS=1`, a source is not hazardous if `cnt[s]==1 & wb_reg_write & wb_dest==s`.
- FSM states:
  - **RUN**
    - `hz & dec_valid`: fd_enable=0, de_bubble=1. Stay in RUN.
    - Else, if `dec_valid & dec_pc_src`: the branch issues, fd_flush=1, go to BR_WAIT with the timer cleared.
    - Otherwise all controls are inactive (fd_enable=1).
  - **BR_WAIT**
    - fd_enable=0, fd_flush=1, de_bubble=1. Younger instructions never issue.
    - On `wb_pc_src`: the PC loads its target at this edge (fetch priority over the hold). Go to RUN; fd_enable=1 from the next cycle.
    - Timer reaches BR_TIMEOUT: set `br_error` and go to RUN.
- A hazard that stalls a branch keeps it in RUN until the hazard clears.

## Timing
- All outputs are combinational from state, scoreboard and inputs. The scoreboard, FSM, timer, error flag and counter are registered.
- Reset (asynchronous): state RUN, all counters 0, busy=0, br_error=0, stall_cycles=0. Outputs during reset: fd_enable=1, fd_flush=0, de_bubble=0.
- Stall latency 0 cycles: a hazard detected in a cycle blocks issue in that cycle.
- Dependent-instruction spacing without bypass: 3 bubbles back-to-back. With WB_BYPASS: 2 bubbles.
- Branch penalty: 3 bubbles from issue to `wb_pc_src`. The first target instruction reaches decode 1 cycle after return to RUN.
- Reset asserted mid-BR_WAIT or mid-stall: returns to RUN immediately, and the scoreboard is cleared.

## Structure
- Package `hazard_pkg`:
  - `state_t` enum {RUN, BR_WAIT}
  - `NOP_INSTR` 22'b0
  - `SB_MAX`=3
- Sub-module `hazard_scoreboard`: counters, busy vector and the bypass-aware hazard compare. Ports: clk, rst, the inc/dec strobes and addresses, the sources and mask, `hz`, `busy`.
- Top level: FSM, branch timer, error flag, stall counter.

## Test plan
- Independent stream (writes R1, R2, R3; reads R4–R6) → de_bubble never 1, stall_cycles stays 0.
- Write R1, then read R1 immediately, WB_BYPASS=1 → exactly 2 de_bubble cycles, fd_enable=0 for the same 2 cycles, busy[1] rises then falls.
- Three back-to-back writes to R5 → cnt[5] reaches 3. Each WB decrements it; busy[5] clears after the third WB.
- Same-cycle issue and WB on R7 (cnt 1) → cnt[7] stays 1.
- Branch issued, `wb_pc_src` 3 cycles later → fd_flush=1 for 4 cycles, then RUN. No non-NOP instruction reaches execute in between.
- Branch with `wb_pc_src` never asserted → br_error=1 after 8 cycles. Reset asserted mid-BR_WAIT → all outputs return to reset values asynchronously.
